// File: rtl/trap_unit.sv
// Machine-mode trap and CSR unit: selects the final next PC and holds mstatus/mtvec/mepc/mcause.
// Optional 64-bit mcycle/minstret counters are compiled in when TRAP_COUNTERS_EN is defined.
module trap_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] pc,
   input  logic [31:0] pc_next,
   input  logic [1:0]  int_cause,
   input  logic        mret,
   input  logic        csr_we,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic [31:0] pc_out,
   output logic        trap_taken,
   output logic        mie_o
);

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_ECALL   = 2'd2,
      CAUSE_EXT_IRQ = 2'd3
   } cause_e;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_COUNTERS_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

   logic        mie_q, mpie_q;
   logic [31:0] mtvec_q, mepc_q, mcause_q;
   logic [31:0] mtvec_rd, mepc_rd;
`ifdef TRAP_COUNTERS_EN
   logic [63:0] mcycle_q, minstret_q;
`endif

   cause_e  cause;
   csr_op_e op;
   logic    exc_take, mret_take, irq_take, trap;
   logic    csr_wr_en;
   logic [31:0] csr_new;

   assign cause    = cause_e'(int_cause);
   assign op       = csr_op_e'(csr_op);
   assign mtvec_rd = {mtvec_q[31:2], 2'b00};
   assign mepc_rd  = {mepc_q[31:2], 2'b00};
   assign mie_o    = mie_q;

   // Priority: stall, exception, MRET, interrupt, CSR write. MRET defers a coincident interrupt.
   assign exc_take  = !stall && (cause == CAUSE_ILLEGAL || cause == CAUSE_ECALL);
   assign mret_take = !stall && !exc_take && mret;
   assign irq_take  = !stall && !exc_take && !mret && cause == CAUSE_EXT_IRQ && mie_q;
   assign trap      = exc_take || irq_take;
   assign csr_wr_en = !stall && !trap && !mret_take && csr_we && op != OP_NONE;

   assign trap_taken = trap && !rst;

   always_comb begin
      pc_out = pc_next;
      if (!rst) begin
         if (trap)           pc_out = mtvec_rd;
         else if (mret_take) pc_out = mepc_rd;
      end
   end

   // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         ADDR_MSTATUS:   csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         ADDR_MTVEC:     csr_rdata = mtvec_rd;
         ADDR_MEPC:      csr_rdata = mepc_rd;
         ADDR_MCAUSE:    csr_rdata = mcause_q;
`ifdef TRAP_COUNTERS_EN
         ADDR_MCYCLE:    csr_rdata = mcycle_q[31:0];
         ADDR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
         ADDR_MINSTRET:  csr_rdata = minstret_q[31:0];
         ADDR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
         default:        csr_rdata = 32'h0;
      endcase
   end

   // Read-modify-write on the pre-update value; per-register masking happens at the store.
   always_comb begin
      csr_new = csr_rdata;
      case (op)
         OP_WRITE: csr_new = csr_wdata;
         OP_SET:   csr_new = csr_rdata | csr_wdata;
         OP_CLEAR: csr_new = csr_rdata & ~csr_wdata;
         default:  csr_new = csr_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from old values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mtvec_q  <= MTVEC_RESET & ~32'h3;
         mepc_q   <= 32'h0;
         mcause_q <= 32'h0;
      end else if (trap) begin
         mepc_q   <= exc_take ? pc : pc_next;
         mcause_q <= (cause == CAUSE_ILLEGAL) ? 32'd2 :
                     (cause == CAUSE_ECALL)   ? 32'd11 : 32'h8000_000B;
         mpie_q   <= mie_q;
         mie_q    <= 1'b0;
      end else if (mret_take) begin
         mie_q    <= mpie_q;
         mpie_q   <= 1'b1;
      end else if (csr_wr_en) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mie_q  <= csr_new[3];
               mpie_q <= csr_new[7];
            end
            ADDR_MTVEC:  mtvec_q  <= csr_new & ~32'h3;
            ADDR_MEPC:   mepc_q   <= csr_new & ~32'h3;
            ADDR_MCAUSE: mcause_q <= csr_new;
            default: ;
         endcase
      end
   end

`ifdef TRAP_COUNTERS_EN
   logic [63:0] mcycle_inc, minstret_inc;
   assign mcycle_inc   = mcycle_q + 64'd1;
   assign minstret_inc = (stall || exc_take) ? minstret_q : minstret_q + 64'd1;

   // A CSR write to either half replaces the whole counter's increment for that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_q   <= 64'h0;
         minstret_q <= 64'h0;
      end else begin
         mcycle_q   <= mcycle_inc;
         minstret_q <= minstret_inc;
         if (csr_wr_en) begin
            case (csr_addr)
               ADDR_MCYCLE:    mcycle_q   <= {mcycle_q[63:32], csr_new};
               ADDR_MCYCLEH:   mcycle_q   <= {csr_new, mcycle_q[31:0]};
               ADDR_MINSTRET:  minstret_q <= {minstret_q[63:32], csr_new};
               ADDR_MINSTRETH: minstret_q <= {csr_new, minstret_q[31:0]};
               default: ;
            endcase
         end
      end
   end
`endif

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit; counter checks follow TRAP_COUNTERS_EN.
module tb_trap_unit;

   logic        clk = 1'b0;
   logic        rst, stall, mret, csr_we;
   logic [31:0] pc, pc_next, csr_wdata;
   logic [1:0]  int_cause, csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata, pc_out;
   logic        trap_taken, mie_o;

   int n_checks = 0;
   int n_errors = 0;

   trap_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pc_next(pc_next),
      .int_cause(int_cause), .mret(mret), .csr_we(csr_we), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .pc_out(pc_out), .trap_taken(trap_taken), .mie_o(mie_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; mret = 0; csr_we = 0; csr_op = 2'b00; int_cause = 2'd0;
      csr_wdata = 32'h0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   initial begin
      rst = 1; pc = 32'h0; pc_next = 32'h4; csr_addr = 12'h0;
      idle();
      tick();
      // Trap and redirect are suppressed while reset is held.
      int_cause = 2'd2; pc_next = 32'h44; #1;
      check("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
      check("rst_pc_out", pc_out, 32'h44);
      tick();
      rst = 0; idle(); #1;
      rd("reset_mtvec", 12'h305, 32'h100);
      rd("reset_mstatus", 12'h300, 32'h0000_1800);
      rd("reset_mepc", 12'h341, 32'h0);
      rd("reset_mcause", 12'h342, 32'h0);
      check("reset_mie", {31'b0, mie_o}, 32'h0);

      // ecall with MIE=0 is taken.
      pc = 32'h40; pc_next = 32'h44; int_cause = 2'd2; #1;
      check("ecall_taken", {31'b0, trap_taken}, 32'h1);
      check("ecall_pc_out", pc_out, 32'h100);
      tick(); idle();
      rd("ecall_mepc", 12'h341, 32'h40);
      rd("ecall_mcause", 12'h342, 32'd11);

      // Set MIE, then take an external interrupt.
      csr_we = 1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
      tick(); idle();
      rd("set_mie_mstatus", 12'h300, 32'h0000_1808);
      check("set_mie_o", {31'b0, mie_o}, 32'h1);
      pc = 32'h80; pc_next = 32'h84; int_cause = 2'd3; #1;
      check("irq_taken", {31'b0, trap_taken}, 32'h1);
      check("irq_pc_out", pc_out, 32'h100);
      tick(); idle();
      rd("irq_mepc", 12'h341, 32'h84);
      rd("irq_mcause", 12'h342, 32'h8000_000B);
      rd("irq_mstatus", 12'h300, 32'h0000_1880);

      // Interrupt masked while MIE=0.
      pc_next = 32'h90; int_cause = 2'd3; #1;
      check("masked_irq_taken", {31'b0, trap_taken}, 32'h0);
      check("masked_irq_pc_out", pc_out, 32'h90);
      tick();

      // MRET with a pending interrupt: return wins, interrupt follows next cycle.
      mret = 1; #1;
      check("mret_pc_out", pc_out, 32'h84);
      check("mret_no_trap", {31'b0, trap_taken}, 32'h0);
      tick();
      mret = 0; #1;
      rd("mret_mstatus", 12'h300, 32'h0000_1888);
      check("deferred_irq_taken", {31'b0, trap_taken}, 32'h1);
      tick(); idle();
      rd("deferred_irq_mepc", 12'h341, 32'h90);

      // Illegal instruction drops a coincident mtvec write.
      pc = 32'h200; pc_next = 32'h204; int_cause = 2'd1;
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'hABC; #1;
      check("illegal_pc_out", pc_out, 32'h100);
      tick(); idle();
      rd("illegal_mtvec_kept", 12'h305, 32'h100);
      rd("illegal_mepc", 12'h341, 32'h200);
      rd("illegal_mcause", 12'h342, 32'd2);

      // Stall blocks the trap and a CSR write.
      stall = 1; int_cause = 2'd2; pc = 32'h300; pc_next = 32'h304;
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h342; csr_wdata = 32'h55; #1;
      check("stall_no_trap", {31'b0, trap_taken}, 32'h0);
      check("stall_pc_out", pc_out, 32'h304);
      tick(); idle();
      rd("stall_mepc", 12'h341, 32'h200);
      rd("stall_mcause", 12'h342, 32'd2);

      // CSR op rules and masking.
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'hABF;
      tick(); idle();
      rd("mtvec_low_bits", 12'h305, 32'hABC);
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h300; csr_wdata = 32'hFFFF_FFFF;
      tick(); idle();
      rd("mstatus_write_mask", 12'h300, 32'h0000_1888);
      csr_we = 1; csr_op = 2'b11; csr_addr = 12'h300; csr_wdata = 32'h80;
      tick(); idle();
      rd("mstatus_clear", 12'h300, 32'h0000_1808);
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h342; csr_wdata = 32'hDEAD_BEEF; #1;
      check("rdata_pre_update", csr_rdata, 32'd2);
      tick(); idle();
      rd("mcause_full", 12'h342, 32'hDEAD_BEEF);
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h123;
      tick(); idle();
      rd("mepc_low_bits", 12'h341, 32'h120);
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h5;
      tick(); idle();
      rd("unmapped_read", 12'h7C0, 32'h0);

      // Reset mid-handler restores reset values.
      rst = 1; tick(); rst = 0; #1;
      rd("rerst_mtvec", 12'h305, 32'h100);
      rd("rerst_mstatus", 12'h300, 32'h0000_1800);
      rd("rerst_mepc", 12'h341, 32'h0);

`ifdef TRAP_COUNTERS_EN
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
      tick();
      csr_addr = 12'hB80; csr_wdata = 32'h0;
      tick(); idle();
      tick(); tick();
      rd("mcycle_low_wrap", 12'hB00, 32'h1);
      rd("mcycle_high_carry", 12'hB80, 32'h1);
`else
      csr_we = 1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 32'h1234;
      tick(); idle();
      rd("no_counter_read", 12'hB00, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap and CSR unit, directly downstream of the CPU control unit. Consumes the control unit's `IntCause`/`MRet` decode together with the datapath PC and selects the final next PC: trap vector, `mepc` on return, or the normal next PC. Holds the machine CSRs (`mstatus`, `mtvec`, `mepc`, `mcause`), updates them on trap entry and return, and serves CSR read/write accesses for the datapath.

## Interface
- `MTVEC_RESET`, default `32'h0000_0100`: reset value of `mtvec`; bits [1:0] are ignored and taken as 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: when high, no CSR, trap or return state changes this cycle; `pc_out`=`pc_next`; `trap_taken`=0.
- `pc` in 32: PC of the executing instruction.
- `pc_next` in 32: next PC chosen by the datapath (sequential, branch or jump).
- `int_cause` in 2: 0=none, 1=illegal instruction, 2=ecall, 3=external interrupt.
- `mret` in 1: executing instruction is MRET.
- `csr_we` in 1: CSR write strobe.
- `csr_op` in 2: 01=write, 10=set bits, 11=clear bits; 00=no write.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in 32: operand for the CSR write.
- `csr_rdata` out 32: combinational read of `csr_addr`, pre-update (old) value.
- `pc_out` out 32: final next PC, combinational.
- `trap_taken` out 1: combinational; high in a cycle whose trap entry commits at the next edge.
- `mie_o` out 1: current `mstatus.MIE`.

## Operation
- CSR map:
  - `mstatus` 0x300: MIE is bit 3, MPIE is bit 7; bits 12:11 (MPP) read as 2'b11; all other bits read 0; only MIE and MPIE are writable.
  - `mtvec` 0x305: bits [1:0] read 0.
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342: fully readable and writable.
  - Unmapped addresses read 0; writes to them are ignored.
- Trap decision:
  - `int_cause` 1 or 2: the trap is always taken, even when MIE=0; this overwrites `mepc`.
  - `int_cause` 3: the trap is taken only when MIE=1; with MIE=0 the cycle proceeds as no trap.
- Trap entry at the clock edge:
  - `mepc` is loaded with:
    - `pc` for causes 1 and 2.
    - `pc_next` for cause 3, since that instruction completes.
  - `mcause` is loaded with:
    - 2 for cause 1.
    - 11 for cause 2.
    - 32'h8000_000B for cause 3.
  - MPIE is loaded with MIE; MIE is cleared.
  - `pc_out`=`mtvec`.
- MRET (no trap taken): MIE is loaded with MPIE, MPIE is set to 1, and `pc_out`=`mepc`.
- Otherwise `pc_out`=`pc_next`.
- Priority, highest first: `rst`, then `stall`, then exception (cause 1 or 2), then MRET, then interrupt, then CSR write.
  - `mret` together with `int_cause`=3: MRET executes and the interrupt is deferred. The interrupt input is level-sensitive, so it is re-evaluated next cycle with the restored MIE.
  - A trap or MRET in the same cycle as `csr_we` drops the CSR write.
- CSR write update rules:
  - write: new = `wdata`.
  - set: new = old | `wdata`.
  - clear: new = old & ~`wdata`.
  - Read-only and zero fields are then re-masked.

## Timing
- `pc_out`, `trap_taken` and `csr_rdata` are combinational, with zero latency. All CSR state updates at the rising edge ending the cycle.
- The handler's first instruction executes the cycle after `trap_taken`. A CSR read in that instruction sees the new `mepc`/`mcause`.
- Reset values (synchronous):
  - MIE=0, MPIE=0.
  - `mtvec`=`MTVEC_RESET`&~3.
  - `mepc`=0, `mcause`=0.
  - Counters (if present) = 0.
  - `trap_taken`=0 while `rst` is high.
  - `pc_out`=`pc_next` while `rst` is high.
- Reset mid-handler returns to reset values; there is no pending state kept across reset.
- A back-to-back exception inside a handler (MIE=0) is taken and overwrites `mepc`/`mcause`.

## Configuration
- `TRAP_COUNTERS_EN` defined: adds 64-bit `mcycle` and `minstret` counters.
  - `mcycle` increments every non-reset cycle.
  - `minstret` increments each non-stalled cycle with no exception taken.
  - Readable at 0xB00/0xB80 (`mcycle` low/high) and 0xB02/0xB82 (`minstret` low/high).
  - Writable with the normal op rules; a write in a cycle replaces that cycle's increment.
  - The low word wraps 32'hFFFF_FFFF→0 with a carry into the high word.
- `TRAP_COUNTERS_EN` undefined: no counter logic; those addresses read 0 and ignore writes.

## Test plan
- Reset, then read 0x305 → `csr_rdata`=32'h100; read 0x300 → 32'h0000_1800.
- MIE=0, pc=0x40, `int_cause`=2 → `trap_taken`=1, `pc_out`=0x100; next cycle `mepc`=0x40, `mcause`=11.
- Set MIE (set op, 0x300, wdata=8), then `int_cause`=3 with pc_next=0x84 → trap taken; `mepc`=0x84, `mcause`=0x8000_000B, MIE=0, MPIE=1. Then `mret`=1 → `pc_out`=0x84, MIE=1.
- MIE=0 with `int_cause`=3 → `trap_taken`=0, `pc_out`=`pc_next`. `mret`=1 with `int_cause`=3 at MPIE=1 → `pc_out`=`mepc`, no trap that cycle; trap taken the following cycle.
- `csr_we`=1 writing 0xABC to `mtvec` in the same cycle as `int_cause`=1 → trap to the old `mtvec`; `mtvec` unchanged. With `stall`=1 and `int_cause`=2 → no state change.
- `TRAP_COUNTERS_EN`: write 0xB00=32'hFFFF_FFFF and 0xB80=0, run 2 cycles → 0xB00 reads 1, 0xB80 reads 1.
